// File: rtl/arm_pkg.sv
// Shared constants and elaboration helpers for the approximate recursive multiplier.
package arm_pkg;

   // Width of one multiplier core operand (a radix-16 digit).
   localparam int CORE_W = 4;

   // Number of 4-bit digits per operand.
   function automatic int k_of(input int width);
      return width / CORE_W;
   endfunction

   // Width of the approximation level field: enough to encode 0..2K-1.
   function automatic int lvl_w(input int width);
      return $clog2(2 * k_of(width));
   endfunction

   // All-ones pattern for a 2*width-bit product, used as the saturation value.
   function automatic logic [63:0] sat_pattern(input int width);
      return (64'd1 << (2 * width)) - 64'd1;
   endfunction

endpackage

// File: rtl/arm_core_4x4.sv
// 4x4 unsigned multiplier core: exact product, or the M1 compressor approximation.
module arm_core_4x4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       approx,
   output logic [7:0] y
);

   logic [3:0][3:0] p;
   logic [1:0]      s1;
   logic [1:0]      s5;
   logic [1:0]      s6;
   logic            c2, c3, c4;
   logic            p20, g20, p21, g21, p30, g30, p31, g31;
   logic [7:0]      approx_y;
   logic [7:0]      exact_y;

   // Partial products, compressor network and final mode select.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            p[i][j] = a[i] & b[j];
         end
      end
      s1  = {1'b0, p[0][1]} + {1'b0, p[1][0]};
      p20 = p[2][0] | p[0][2];
      g20 = p[2][0] & p[0][2];
      p21 = p[2][1] | p[1][2];
      g21 = p[2][1] & p[1][2];
      p30 = p[3][0] | p[0][3];
      g30 = p[3][0] & p[0][3];
      p31 = p[3][1] | p[1][3];
      g31 = p[3][1] & p[1][3];
      c2  = g20 | s1[1];
      c3  = (c2 & (g30 | g21)) | (p21 & p30);
      c4  = g31 | (p[2][2] & c3);
      s5  = {1'b0, p[3][2]} + {1'b0, p[2][3]} + {1'b0, c4};
      s6  = {1'b0, p[3][3]} + {1'b0, s5[1]};
      approx_y[0] = p[0][0];
      approx_y[1] = s1[0];
      approx_y[2] = p20 | p[1][1];
      approx_y[3] = c2 | p21 | p30;
      approx_y[4] = p31 | g31 | p[2][2];
      approx_y[5] = s5[0];
      approx_y[6] = s6[0];
      approx_y[7] = s6[1];
      exact_y     = {4'b0000, a} * {4'b0000, b};
      if (approx) begin
         y = approx_y;
      end else begin
         y = exact_y;
      end
   end

endmodule

// File: rtl/approx_recursive_mult_pipe.sv
// Two-stage valid/ready recursive multiplier built from K*K 4x4 cores with a
// per-transaction significance threshold selecting approximate cores.
module approx_recursive_mult_pipe
   import arm_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int TAG_W = 4,
   localparam int LVL_W = lvl_w(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [LVL_W-1:0]   in_level,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_y,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_sat
);

   localparam int K     = k_of(WIDTH);
   localparam int NC    = K * K;
   localparam int PW    = 2 * WIDTH;
   localparam int SUM_W = PW + 1;
   localparam logic [63:0] SAT_FULL = sat_pattern(WIDTH);
   localparam logic [PW-1:0] SAT_Y  = SAT_FULL[PW-1:0];

   if (!(WIDTH == 8 || WIDTH == 16)) begin : g_bad_width
      $error("approx_recursive_mult_pipe: WIDTH must be 8 or 16");
   end

   logic [7:0]       core_y [NC];
   logic [7:0]       s1_prod_r [NC];
   logic [TAG_W-1:0] s1_tag_r;
   logic             s1_valid_r;
   logic             en1_s, en2_s, accept_s;
   logic [SUM_W-1:0] sum_s;
   logic [PW-1:0]    y_s;
   logic             sat_s;

   // Core array; core (i,j) is approximate when its digit significance is below the level.
   for (genvar i = 0; i < K; i++) begin : g_row
      for (genvar j = 0; j < K; j++) begin : g_col
         logic apx;
         assign apx = ({1'b0, in_level} > (LVL_W + 1)'(i + j));
         arm_core_4x4 u_core (
            .a      (in_a[CORE_W*i +: CORE_W]),
            .b      (in_b[CORE_W*j +: CORE_W]),
            .approx (apx),
            .y      (core_y[i*K + j])
         );
      end
   end

   assign en2_s    = !out_valid || out_ready;
   assign en1_s    = !s1_valid_r || en2_s;
   assign in_ready = en1_s;
   assign accept_s = in_valid && en1_s;

   // Shifted accumulation of the core products with overflow detection.
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            sum_s = sum_s + (SUM_W'(s1_prod_r[i*K + j]) << (CORE_W * (i + j)));
         end
      end
      sat_s = sum_s[PW];
      if (sat_s) begin
         y_s = SAT_Y;
      end else begin
         y_s = sum_s[PW-1:0];
      end
   end

   // Stage 1: capture the core products and tag of each accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_tag_r   <= '0;
         for (int c = 0; c < NC; c++) begin
            s1_prod_r[c] <= 8'h00;
         end
      end else if (en1_s) begin
         s1_valid_r <= in_valid;
         if (in_valid) begin
            s1_tag_r <= in_tag;
            for (int c = 0; c < NC; c++) begin
               s1_prod_r[c] <= core_y[c];
            end
         end
      end
   end

   // Stage 2: register the summed result; held stable while the sink stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_tag   <= '0;
         out_sat   <= 1'b0;
      end else if (en2_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out_y   <= y_s;
            out_tag <= s1_tag_r;
            out_sat <= sat_s;
         end
      end
   end

endmodule
